// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Quotient bit value replicated across the quotient on divide-by-zero.
  localparam logic DBZ_Q_FILL = 1'b1;

endpackage

// File: rtl/seq_div_if.sv
// Request/result bundle between a divider client and seq_div.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the divider is idle.
interface seq_div_if #(
  parameter int N = 256
);

  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract divisor.
// Latency: purely combinational.
// Backpressure: none.
module div_step #(
  parameter int N = 256
) (
  input  logic [N-1:0] i_rem,
  input  logic         i_bit,
  input  logic [N-1:0] i_dvs,
  output logic [N-1:0] o_rem,
  output logic         o_qbit
);

  logic [N:0] w_shift;
  logic [N:0] w_trial;

  // Shifted remainder is N+1 bits; because i_rem < i_dvs, a non-negative
  // trial always fits in N bits and a negative one always sets bit N.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_trial = w_shift - {1'b0, i_dvs};
    o_qbit  = ~w_trial[N];
    o_rem   = w_trial[N] ? w_shift[N-1:0] : w_trial[N-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Constant-time unsigned restoring divider, 2N/N -> 2N quotient, N remainder.
// Latency: 2N+2 cycles start-to-done (N+2 with SEQ_DIV_RADIX4_EN); divide-by-zero 2.
// Backpressure: start ignored unless idle; results held until next accepted start.
module seq_div
  import div_pkg::*;
#(
  parameter int N = 256
) (
  input logic    clk,
  input logic    rst_n,
  seq_div_if.slave io_bus
);

`ifdef SEQ_DIV_RADIX4_EN
  localparam int ITERS = N;
`else
  localparam int ITERS = 2 * N;
`endif
  localparam int CNT_W = $clog2(2 * N) + 1;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_rem;
  logic [2*N-1:0] r_q;
  logic [N-1:0]   r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic [2*N-1:0] r_quot_o;
  logic [N-1:0]   r_rem_o;
  logic           r_dbz;
  logic           w_busy;
  logic           w_done;
  logic           w_accept;
  logic           w_last;
  logic [N-1:0]   w_rem_nxt;
  logic [2*N-1:0] w_q_nxt;
  logic [N-1:0]   w_r1;
  logic           w_qb1;

  assign w_accept = (r_state == IDLE) && io_bus.start;
  assign w_last   = (r_cnt == CNT_W'(ITERS - 1));

  div_step #(.N(N)) u_step0 (
    .i_rem (r_rem),
    .i_bit (r_q[2*N-1]),
    .i_dvs (r_dvs),
    .o_rem (w_r1),
    .o_qbit(w_qb1)
  );

`ifdef SEQ_DIV_RADIX4_EN
  logic [N-1:0] w_r2;
  logic         w_qb2;

  div_step #(.N(N)) u_step1 (
    .i_rem (w_r1),
    .i_bit (r_q[2*N-2]),
    .i_dvs (r_dvs),
    .o_rem (w_r2),
    .o_qbit(w_qb2)
  );

  assign w_rem_nxt = w_r2;
  assign w_q_nxt   = {r_q[2*N-3:0], w_qb1, w_qb2};
`else
  assign w_rem_nxt = w_r1;
  assign w_q_nxt   = {r_q[2*N-2:0], w_qb1};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: no early exit, DIV always runs the full iteration count.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (io_bus.start) w_next = LOAD;
      LOAD: w_next = (r_dvs == '0) ? DONE : DIV;
      DIV:  if (w_last) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    w_busy = (r_state != IDLE);
    w_done = (r_state == DONE);
  end

  // Datapath: operands latched on accept, results loaded on the edge into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem    <= '0;
      r_q      <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_quot_o <= '0;
      r_rem_o  <= '0;
      r_dbz    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_q   <= io_bus.dividend;
        r_dvs <= io_bus.divisor;
        r_dbz <= 1'b0;
      end
      if (r_state == LOAD) begin
        r_rem <= '0;
        r_cnt <= '0;
        if (r_dvs == '0) begin
          r_quot_o <= {(2*N){DBZ_Q_FILL}};
          r_rem_o  <= r_q[N-1:0];
          r_dbz    <= 1'b1;
        end
      end
      if (r_state == DIV) begin
        r_rem <= w_rem_nxt;
        r_q   <= w_q_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_quot_o <= w_q_nxt;
          r_rem_o  <= w_rem_nxt;
        end
      end
    end
  end

  assign io_bus.quotient    = r_quot_o;
  assign io_bus.remainder   = r_rem_o;
  assign io_bus.busy        = w_busy;
  assign io_bus.done        = w_done;
  assign io_bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div at N=8 and N=256.
// Latency expectations follow SEQ_DIV_RADIX4_EN when it is defined.
// Backpressure: exercises start while busy, in DONE, and on the first idle cycle.
module tb_seq_div;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

`ifdef SEQ_DIV_RADIX4_EN
  localparam int L8   = 8 + 2;
  localparam int L256 = 256 + 2;
`else
  localparam int L8   = 16 + 2;
  localparam int L256 = 512 + 2;
`endif

  seq_div_if #(.N(8))   bus8 ();
  seq_div_if #(.N(256)) bus256 ();

  seq_div #(.N(8))   dut8   (.clk(clk), .rst_n(rst_n), .io_bus(bus8));
  seq_div #(.N(256)) dut256 (.clk(clk), .rst_n(rst_n), .io_bus(bus256));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one N=8 division and follow it to done (+1 cycle). Optionally pulse
  // start mid-DIV (inj = cycle index) and/or raise start during the DONE cycle.
  task automatic go8(input logic [15:0] dvd, input logic [7:0] dvs, input int inj,
                     input bit arm, input logic [15:0] a_dvd, input logic [7:0] a_dvs,
                     output int lat, output int pulses,
                     output logic bsy_done, output logic bsy_after);
    lat = 0;
    pulses = 0;
    bsy_done = 1'b0;
    bus8.start = 1'b1;
    bus8.dividend = dvd;
    bus8.divisor = dvs;
    for (int c = 1; c <= 200 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus8.start = 1'b0;
      if (c == inj) begin
        bus8.start = 1'b1;
        bus8.dividend = 16'd50;
        bus8.divisor = 8'd3;
      end
      if (inj > 0 && c == inj + 1) bus8.start = 1'b0;
      if (bus8.done) begin
        lat = c;
        pulses++;
        bsy_done = bus8.busy;
      end
    end
    if (arm) begin
      bus8.start = 1'b1;
      bus8.dividend = a_dvd;
      bus8.divisor = a_dvs;
    end
    @(posedge clk); #1;
    bsy_after = bus8.busy;
    if (bus8.done) pulses++;
  endtask

  initial begin
    int   lat;
    int   pulses;
    int   dcount;
    logic bd;
    logic ba;
    logic [511:0] big_dvd;
    logic [255:0] big_dvs;

    rst_n = 1'b0;
    bus8.start = 1'b0;
    bus8.dividend = '0;
    bus8.divisor = '0;
    bus256.start = 1'b0;
    bus256.dividend = '0;
    bus256.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quot", 512'(bus8.quotient), 512'd0);
    chk("rst_rem", 512'(bus8.remainder), 512'd0);
    chk("rst_busy", 512'(bus8.busy), 512'd0);
    chk("rst_done", 512'(bus8.done), 512'd0);
    chk("rst_dbz", 512'(bus8.div_by_zero), 512'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1000 / 7 = 142 r 6
    go8(16'd1000, 8'd7, 0, 1'b0, 16'd0, 8'd0, lat, pulses, bd, ba);
    chk("a_quot", 512'(bus8.quotient), 512'd142);
    chk("a_rem", 512'(bus8.remainder), 512'd6);
    chk("a_dbz", 512'(bus8.div_by_zero), 512'd0);
    chk("a_lat", 512'(lat), 512'(L8));
    chk("a_pulses", 512'(pulses), 512'd1);
    chk("a_busy_in_done", 512'(bd), 512'd1);
    chk("a_busy_after", 512'(ba), 512'd0);

    // divisor larger than dividend, then divide by one
    go8(16'd5, 8'd200, 0, 1'b0, 16'd0, 8'd0, lat, pulses, bd, ba);
    chk("b_quot", 512'(bus8.quotient), 512'd0);
    chk("b_rem", 512'(bus8.remainder), 512'd5);
    go8(16'hFFFF, 8'h01, 0, 1'b0, 16'd0, 8'd0, lat, pulses, bd, ba);
    chk("c_quot", 512'(bus8.quotient), 512'hFFFF);
    chk("c_rem", 512'(bus8.remainder), 512'd0);
    chk("c_lat", 512'(lat), 512'(L8));

    // divide by zero
    go8(16'h1234, 8'h00, 0, 1'b0, 16'd0, 8'd0, lat, pulses, bd, ba);
    chk("z_dbz", 512'(bus8.div_by_zero), 512'd1);
    chk("z_quot", 512'(bus8.quotient), 512'hFFFF);
    chk("z_rem", 512'(bus8.remainder), 512'h34);
    chk("z_lat", 512'(lat), 512'd2);
    chk("z_pulses", 512'(pulses), 512'd1);

    // start mid-DIV with other operands, start held through DONE into IDLE
    go8(16'd1000, 8'd7, 5, 1'b1, 16'hABCD, 8'd19, lat, pulses, bd, ba);
    chk("m_quot", 512'(bus8.quotient), 512'd142);
    chk("m_rem", 512'(bus8.remainder), 512'd6);
    chk("m_dbz_cleared", 512'(bus8.div_by_zero), 512'd0);
    chk("m_pulses", 512'(pulses), 512'd1);
    chk("m_done_start_ignored", 512'(ba), 512'd0);

    // accepted on the first IDLE cycle: 43981 / 19 = 2314 r 15
    go8(16'hABCD, 8'd19, 0, 1'b0, 16'd0, 8'd0, lat, pulses, bd, ba);
    chk("bb_quot", 512'(bus8.quotient), 512'd2314);
    chk("bb_rem", 512'(bus8.remainder), 512'd15);
    chk("bb_lat", 512'(lat), 512'(L8));

    // reset during iteration 5 aborts with no done pulse
    bus8.start = 1'b1;
    bus8.dividend = 16'd1000;
    bus8.divisor = 8'd7;
    dcount = 0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus8.start = 1'b0;
      if (bus8.done) dcount++;
    end
    rst_n = 1'b0;
    #1;
    chk("r_quot", 512'(bus8.quotient), 512'd0);
    chk("r_rem", 512'(bus8.remainder), 512'd0);
    chk("r_busy", 512'(bus8.busy), 512'd0);
    chk("r_done", 512'(bus8.done), 512'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus8.done) dcount++;
    end
    chk("r_no_done", 512'(dcount), 512'd0);

    // fresh start after reset: 200 / 9 = 22 r 2
    go8(16'd200, 8'd9, 0, 1'b0, 16'd0, 8'd0, lat, pulses, bd, ba);
    chk("f_quot", 512'(bus8.quotient), 512'd22);
    chk("f_rem", 512'(bus8.remainder), 512'd2);
    chk("f_lat", 512'(lat), 512'(L8));

    // N=256: 2^255 / (2^255 - 19) = 1 r 19
    big_dvd = '0;
    big_dvd[255] = 1'b1;
    big_dvs = '0;
    big_dvs[255] = 1'b1;
    big_dvs = big_dvs - 256'd19;
    bus256.start = 1'b1;
    bus256.dividend = big_dvd;
    bus256.divisor = big_dvs;
    lat = 0;
    for (int c = 1; c <= 2000 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus256.start = 1'b0;
      if (bus256.done) lat = c;
    end
    chk("w_quot", 512'(bus256.quotient), 512'd1);
    chk("w_rem", 512'(bus256.remainder), 512'd19);
    chk("w_dbz", 512'(bus256.div_by_zero), 512'd0);
    chk("w_lat", 512'(lat), 512'(L256));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Sequential restoring divider: 2N-bit dividend by N-bit divisor, producing a 2N-bit quotient and an N-bit remainder.
- Shift-and-subtract, one quotient bit per cycle. It is the inverse-direction companion of the shift-and-add multiplier.
- Feeds mod-p reduction (remainder path) and any datapath needing exact quotients.
- Latency is fixed and data-independent: constant-time, no early exit on data values.

Parameters:
- N, 256: divisor/remainder width; dividend/quotient width is 2N.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  2N  numerator; latched when start is accepted
- divisor  input  N  denominator; latched when start is accepted
- quotient  output  2N  floor(dividend/divisor); held until next accepted start
- remainder  output  N  dividend mod divisor; held until next accepted start
- busy  output  1  high from the cycle after acceptance through the DONE cycle
- done  output  1  single-cycle pulse; results valid from this cycle onward
- div_by_zero  output  1  set with done when the latched divisor == 0; cleared on next accepted start

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk.
  - All outputs, state and counters go to 0; state = IDLE.
  - Reset asserted mid-operation aborts immediately; no done pulse is produced.
- States: IDLE, LOAD, DIV, DONE.
  - IDLE -> LOAD on start=1. Accepted on edge t0.
  - LOAD: latch operands, clear the working remainder register R (N+1 bits) and cnt.
    - If divisor==0: go to DONE with quotient = all ones, remainder = dividend[N-1:0], div_by_zero=1.
  - DIV: per cycle, shift {R, Q} left by 1 (Q is the shifting dividend/quotient register).
    - Compute trial = R - {1'b0, divisor} at N+1 bits.
    - If trial is non-negative: R = trial, Q[0] = 1; else R unchanged, Q[0] = 0.
    - cnt counts 0..2N-1; after 2N iterations go to DONE.
  - DONE: drive quotient = Q, remainder = R[N-1:0]; done=1 for exactly one cycle, then return to IDLE.
- Latency:
  - Normal: done is high during the cycle following edge t0+2N+1 (2N+2 cycles start-to-result).
  - Divide by zero: done follows edge t0+1. Divisor-zero is public info, so this is not a timing leak.
- Handshake:
  - start while busy is ignored; it is neither queued nor allowed to corrupt the operation in flight.
  - start in the DONE cycle is ignored.
  - start on the first IDLE cycle after DONE is accepted (back-to-back throughput = 2N+3 cycles).
- Outputs quotient/remainder change only in the DONE cycle.
- Arithmetic:
  - Unsigned only.
  - The remainder invariant R < divisor holds after every DIV step.
  - The subtraction is N+1 bits wide; no width truncation is allowed.
- cnt width is $clog2(2N)+1 bits; it must not wrap before reaching 2N.

Optional Feature:
- Macro SEQ_DIV_RADIX4_EN.
- Defined: two restoring steps are chained combinationally per cycle, so DIV lasts N cycles and done follows edge t0+N+1. Results and the divide-by-zero behaviour are identical to the radix-2 build.
- Undefined: radix-2 as described above.

Decomposition:
- Package div_pkg: state enum (IDLE, LOAD, DIV, DONE), state width localparam, and the divide-by-zero quotient fill constant.
- Sub-module div_step: purely combinational single restoring step.
  - Inputs: R, next dividend bit, divisor.
  - Outputs: new R, quotient bit.
- div_step is instantiated once, or twice chained under SEQ_DIV_RADIX4_EN.

Test Plan:
- N=8, dividend=16'd1000, divisor=8'd7 -> quotient=142, remainder=6, div_by_zero=0, done exactly 18 cycles after the accepting edge.
- N=8, dividend=16'd5, divisor=8'd200 -> quotient=0, remainder=5; then dividend=16'hFFFF, divisor=8'h01 -> quotient=16'hFFFF, remainder=0.
- N=8, divisor=0, dividend=16'h1234 -> div_by_zero=1, quotient=16'hFFFF, remainder=8'h34, done 2 cycles after acceptance.
- start pulsed again mid-DIV with different operands -> first result is unaffected, only one done pulse; start on the first IDLE cycle after DONE -> second result is correct.
- rst_n dropped at iteration 5 -> all outputs 0 immediately, no done pulse; a fresh start afterwards computes correctly.
- N=256, dividend=2^255, divisor=2^255-19 -> quotient=1, remainder=19; repeat with SEQ_DIV_RADIX4_EN -> same result, latency N+2 cycles.
